// File: rtl/palette_pkg.sv
// palette_pkg: shared palette widths, requester id and response tag types.
package palette_pkg;
    localparam int PAL_ADDR_W = 5;
    localparam int PAL_DATA_W = 24;
    localparam int MAX_REQ = 8;
    localparam int ID_W = $clog2(MAX_REQ);
    typedef logic [PAL_ADDR_W-1:0] pal_addr_t;
    typedef logic [PAL_DATA_W-1:0] pal_rgb_t;
    typedef logic [ID_W-1:0] req_id_t;
    typedef struct packed {
        logic valid;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/palette_arbiter_if.sv
// palette_arbiter_if: requester bus plus palette ROM port of the shared palette arbiter.
interface palette_arbiter_if import palette_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = PAL_ADDR_W,
    parameter int DATA_W = PAL_DATA_W
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] pal_addr;
    logic [DATA_W-1:0] pal_data;
    modport master (
        output req, req_addr, pal_data,
        input gnt, rsp_valid, rsp_data, pal_addr
    );
    modport slave (
        input req, req_addr, pal_data,
        output gnt, rsp_valid, rsp_data, pal_addr
    );
endinterface

// File: rtl/palette_arbiter_rr_picker.sv
// rr_picker: rotating priority encoder; first set req bit at or after ptr wins.
module rr_picker import palette_pkg::*; #(
    parameter int N = 4
) (
    input logic [N-1:0] req,
    input req_id_t ptr,
    output logic [N-1:0] gnt,
    output req_id_t idx
);
    // scan offsets from farthest to nearest so the nearest requester overwrites
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx = req_id_t'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/palette_arbiter.sv
// palette_arbiter: round-robin sharing of one synchronous palette ROM among sprite pipelines.
// Define PALETTE_ARB_BG_PRIO_EN to give requester 0 (background) absolute priority.
module palette_arbiter import palette_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = PAL_ADDR_W,
    parameter int DATA_W = PAL_DATA_W,
    parameter int ROM_LAT = 1
) (
    input logic Clk,
    input logic Reset_n,
    palette_arbiter_if.slave bus
);
    localparam req_id_t LAST = req_id_t'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ - 1){1'b0}}, 1'b1};
`ifdef PALETTE_ARB_BG_PRIO_EN
    localparam req_id_t FIRST = req_id_t'(1);
`else
    localparam req_id_t FIRST = '0;
`endif
    req_id_t rr_ptr, rr_idx, idx;
    logic [NUM_REQ-1:0] req_m, rr_gnt, gnt;
    logic adv;
    logic [DATA_W-1:0] rsp_data;
    tag_t pipe [ROM_LAT];
    assign req_m = bus.req & {NUM_REQ{Reset_n}};
    rr_picker #(.N(NUM_REQ)) u_pick (
        .req(req_m),
        .ptr(rr_ptr),
        .gnt(rr_gnt),
        .idx(rr_idx)
    );
`ifdef PALETTE_ARB_BG_PRIO_EN
    // background bypasses the rotation and leaves rr_ptr untouched
    assign gnt = req_m[0] ? ONE : rr_gnt;
    assign idx = req_m[0] ? '0 : rr_idx;
    assign adv = |rr_gnt & ~req_m[0];
`else
    assign gnt = rr_gnt;
    assign idx = rr_idx;
    assign adv = |rr_gnt;
`endif
    assign rsp_data = bus.pal_data;
    assign bus.gnt = gnt;
    assign bus.pal_addr = |gnt ? bus.req_addr[int'(idx) * ADDR_W +: ADDR_W] : '0;
    assign bus.rsp_data = rsp_data;
    assign bus.rsp_valid = pipe[ROM_LAT-1].valid ? ONE << pipe[ROM_LAT-1].id : '0;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr <= FIRST;
            for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
        end else begin
            if (adv) rr_ptr <= (idx == LAST) ? FIRST : idx + req_id_t'(1);
            pipe[0] <= '{valid: |gnt, id: idx};
            for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
endmodule
